// File: rtl/block_sync.sv
// block_sync: receive-side 64b/66b block aligner and gearbox.
// Turns a continuous 32-bit transceiver stream into per-block beats for the
// descrambler: a header beat carrying the sync header and payload[31:0],
// then a data beat carrying payload[63:32]. A slip request drops one stream bit
// so an external lock FSM can walk the framing until headers line up.
module block_sync #(
   parameter int DATA_WIDTH = 32,
   parameter int HDR_WIDTH  = 2
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_rx_data,
   input  logic                  i_slip,
   output logic [DATA_WIDTH-1:0] o_tx_data,
   output logic [HDR_WIDTH-1:0]  o_tx_sync_hdr,
   output logic                  o_tx_data_valid
);

   // Residual buffer holds at most 33 bits; stream = residual + one word.
   localparam int RES_W = DATA_WIDTH + 1;
   localparam int STR_W = RES_W + DATA_WIDTH;
   localparam int HB_W  = HDR_WIDTH + DATA_WIDTH;
   localparam int CNT_W = $clog2(STR_W + 1);

   typedef enum logic {
      PH_HDR,
      PH_DATA
   } phase_e;

   logic [DATA_WIDTH-1:0] rx_data_q;
   logic                  slip_q;

   logic [RES_W-1:0]      res_q,      res_d;
   logic [CNT_W-1:0]      fill_q,     fill_d;
   phase_e                phase_q,    phase_d;
   logic [DATA_WIDTH-1:0] tx_data_q,  tx_data_d;
   logic [HDR_WIDTH-1:0]  tx_hdr_q,   tx_hdr_d;
   logic                  tx_valid_q, tx_valid_d;

   logic [STR_W-1:0]      cat_s;
   logic [STR_W-1:0]      str_s;
   logic [CNT_W-1:0]      len_s;

   // Input register: capture the transceiver word and slip request every cycle.
   // NOTE: no reset here on purpose; the word present in the last reset cycle
   // must survive so it becomes the first word processed after reset.
   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments for all registered state, so every
      // flop samples the pre-edge value regardless of statement order.
      rx_data_q <= i_rx_data;
      slip_q    <= i_slip;
   end

   // Gearbox: append the word above the residue, apply slip, emit one beat.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no path
      // leaves one unassigned and no latch is inferred.
      cat_s      = ({{RES_W{1'b0}}, rx_data_q} << fill_q) | {{DATA_WIDTH{1'b0}}, res_q};
      str_s      = slip_q ? (cat_s >> 1) : cat_s;
      len_s      = fill_q + CNT_W'(DATA_WIDTH) - CNT_W'(slip_q);
      res_d      = RES_W'(str_s);
      fill_d     = len_s;
      phase_d    = phase_q;
      tx_data_d  = tx_data_q;
      tx_hdr_d   = tx_hdr_q;
      tx_valid_d = 1'b0;

      if (phase_q == PH_HDR && len_s >= CNT_W'(HB_W)) begin
         tx_hdr_d   = str_s[HDR_WIDTH-1:0];
         tx_data_d  = str_s[HDR_WIDTH +: DATA_WIDTH];
         tx_valid_d = 1'b1;
         res_d      = RES_W'(str_s >> HB_W);
         fill_d     = len_s - CNT_W'(HB_W);
         phase_d    = PH_DATA;
      end else if (phase_q == PH_DATA && len_s >= CNT_W'(DATA_WIDTH)) begin
         tx_data_d  = str_s[DATA_WIDTH-1:0];
         tx_valid_d = 1'b1;
         res_d      = RES_W'(str_s >> DATA_WIDTH);
         fill_d     = len_s - CNT_W'(DATA_WIDTH);
         phase_d    = PH_HDR;
      end
      // Otherwise stall: keep the whole stream as residue, phase unchanged.
   end

   // Gearbox state and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         res_q      <= '0;
         fill_q     <= '0;
         phase_q    <= PH_HDR;
         tx_data_q  <= '0;
         tx_hdr_q   <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         res_q      <= res_d;
         fill_q     <= fill_d;
         phase_q    <= phase_d;
         tx_data_q  <= tx_data_d;
         tx_hdr_q   <= tx_hdr_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign o_tx_data       = tx_data_q;
   assign o_tx_sync_hdr   = tx_hdr_q;
   assign o_tx_data_valid = tx_valid_q;

endmodule

// File: tb/tb_block_sync.sv
// tb_block_sync: scoreboard bench for the 64b/66b block aligner.
// Stimulus builds a bit stream of 66-bit blocks and pushes each block's two
// expected beats into a queue; a negedge monitor pops and compares whenever
// the DUT presents a valid beat.
module tb_block_sync;

   logic        i_clk;
   logic        i_reset_n;
   logic [31:0] i_rx_data;
   logic        i_slip;
   logic [31:0] o_tx_data;
   logic [1:0]  o_tx_sync_hdr;
   logic        o_tx_data_valid;

   block_sync #(
      .DATA_WIDTH(32),
      .HDR_WIDTH (2)
   ) dut (
      .i_clk          (i_clk),
      .i_reset_n      (i_reset_n),
      .i_rx_data      (i_rx_data),
      .i_slip         (i_slip),
      .o_tx_data      (o_tx_data),
      .o_tx_sync_hdr  (o_tx_sync_hdr),
      .o_tx_data_valid(o_tx_data_valid)
   );

   // Expected beat; dc = any beat accepted, hunt = skip beats until this one matches.
   typedef struct {
      logic [1:0]  hdr;
      logic [31:0] data;
      bit          dc;
      bit          hunt;
   } beat_t;

   beat_t exp_q[$];
   bit    bits_q[$];

   int n_checks   = 0;
   int n_pass     = 0;
   int beat_no    = 0;
   int beats_seen = 0;
   int word_idx   = 0;

   bit gap_track = 0;
   int gap_rel   = -1;
   int gap_pos[$];

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic push_exp(input logic [1:0] h, input logic [31:0] d, input bit dc, input bit hunt);
      beat_t b;
      b.hdr  = h;
      b.data = d;
      b.dc   = dc;
      b.hunt = hunt;
      exp_q.push_back(b);
   endtask

   // Append one block to the stream (header bit 0 first); optionally expect it.
   task automatic add_block(input logic [1:0] hdr, input logic [63:0] pl,
                            input bit exp_hdr, input bit exp_dat, input bit hunt);
      for (int i = 0; i < 2; i++)  bits_q.push_back(hdr[i]);
      for (int i = 0; i < 64; i++) bits_q.push_back(pl[i]);
      if (exp_hdr) push_exp(hdr, pl[31:0], 1'b0, hunt);
      if (exp_dat) push_exp(hdr, pl[63:32], 1'b0, 1'b0);
   endtask

   task automatic add_random_blocks(input int n, input bit expect_it);
      for (int i = 0; i < n; i++) begin
         logic [1:0]  h;
         logic [63:0] p;
         h = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
         p = {$urandom, $urandom};
         add_block(h, p, expect_it, expect_it, 1'b0);
      end
   endtask

   function automatic logic [31:0] next_word();
      logic [31:0] w;
      w = '0;
      for (int i = 0; i < 32; i++)
         if (bits_q.size() > 0) w[i] = bits_q.pop_front();
      return w;
   endfunction

   // Drive one word, clock it, and observe outputs 1 time unit after the edge.
   task automatic step(input logic [31:0] w, input logic s);
      i_rx_data = w;
      i_slip    = s;
      @(posedge i_clk);
      #1;
      if (o_tx_data_valid === 1'b1) beats_seen++;
      if (gap_track) begin
         if (gap_rel < 0 && o_tx_data_valid === 1'b1) gap_rel = 0;
         else if (gap_rel >= 0) gap_rel++;
         if (gap_rel >= 0 && gap_rel < 66 && o_tx_data_valid !== 1'b1) gap_pos.push_back(gap_rel);
      end
   endtask

   task automatic check_reset_outs();
      check("reset_data",  64'(o_tx_data),       64'd0);
      check("reset_hdr",   64'(o_tx_sync_hdr),   64'd0);
      check("reset_valid", 64'(o_tx_data_valid), 64'd0);
   endtask

   task automatic reset_begin();
      i_reset_n = 1'b0;
      step($urandom, 1'b0);
      check_reset_outs();
   endtask

   // Two more reset cycles; the last one captures the first stream word.
   task automatic reset_end();
      step($urandom, 1'b0);
      check_reset_outs();
      step(next_word(), 1'b0);
      check_reset_outs();
      i_reset_n  = 1'b1;
      word_idx   = 1;
      beats_seen = 0;
   endtask

   task automatic run_words(input int n, input int s_first, input int s_num, input int s_every);
      for (int k = 0; k < n; k++) begin
         int   d;
         logic s;
         d = word_idx - s_first;
         s = (s_num > 0 && d >= 0 && (d % s_every) == 0 && (d / s_every) < s_num);
         step(next_word(), s);
         word_idx++;
      end
      i_slip = 1'b0;
   endtask

   task automatic run_stream(input int s_first, input int s_num, input int s_every);
      run_words((bits_q.size() + 31) / 32 + 4, s_first, s_num, s_every);
   endtask

   task automatic wait_drain(input string name);
      for (int k = 0; k < 200 && exp_q.size() > 0; k++) step(32'd0, 1'b0);
      check(name, 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard monitor: sample on the falling edge, compare against queue head.
   always @(negedge i_clk) begin
      beat_t e;
      bit    hit;
      if (o_tx_data_valid === 1'b1 && exp_q.size() > 0) begin
         e   = exp_q[0];
         hit = (o_tx_sync_hdr === e.hdr) && (o_tx_data === e.data);
         if (e.dc) begin
            void'(exp_q.pop_front());
         end else if (!e.hunt || hit) begin
            void'(exp_q.pop_front());
            check($sformatf("beat%0d", beat_no), {30'd0, o_tx_sync_hdr, o_tx_data},
                  {30'd0, e.hdr, e.data});
            beat_no++;
         end
      end
   end

   initial begin
      int g0;
      int g1;
      i_reset_n = 1'b0;
      i_rx_data = '0;
      i_slip    = 1'b0;

      // Reset with random data, then an aligned stream of 500 blocks.
      reset_begin();
      add_block(2'b01, 64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 1'b0);
      add_block(2'b10, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b1, 1'b0);
      add_block(2'b01, 64'h8000_0000_0000_0001, 1'b1, 1'b1, 1'b0);
      add_random_blocks(497, 1'b1);
      reset_end();
      gap_track = 1;
      gap_rel   = -1;
      run_stream(0, 0, 1);
      gap_track = 0;
      wait_drain("aligned_drain");

      // Gap cadence over the first 66 cycles of output.
      g0 = (gap_pos.size() > 0) ? gap_pos[0] : -1;
      g1 = (gap_pos.size() > 1) ? gap_pos[1] : -1;
      check("gap_count",   64'(gap_pos.size()), 64'd2);
      check("gap_first",   64'(g0),             64'd32);
      check("gap_spacing", 64'(g1 - g0),        64'd33);

      // Single slip: one junk bit ahead of the blocks, slip processed in a
      // header-phase cycle after blocks 0 and 1 came out misaligned.
      reset_begin();
      bits_q.delete();
      exp_q.delete();
      bits_q.push_back(1'b1);
      add_random_blocks(2, 1'b0);
      for (int i = 0; i < 4; i++) push_exp(2'b00, 32'd0, 1'b1, 1'b0);
      add_random_blocks(38, 1'b1);
      reset_end();
      run_stream(5, 1, 4);
      wait_drain("slip1_drain");

      // Slip sweep: aligned blocks, then a junk gap of 65 + 150*66 bits absorbed
      // by 65 slips, after which the following blocks are aligned again.
      reset_begin();
      bits_q.delete();
      exp_q.delete();
      add_random_blocks(20, 1'b1);
      for (int i = 0; i < 65 + 66 * 150; i++) bits_q.push_back(1'b0);
      add_block(2'b10, 64'hA5A5_0F0F_3C3C_9696, 1'b1, 1'b1, 1'b1);
      add_random_blocks(29, 1'b1);
      reset_end();
      run_stream(60, 65, 4);
      wait_drain("sweep_drain");

      // Mid-operation reset right after the fifth header beat.
      reset_begin();
      bits_q.delete();
      exp_q.delete();
      add_random_blocks(4, 1'b1);
      add_block(2'b01, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 1'b0, 1'b0);
      add_random_blocks(5, 1'b0);
      reset_end();
      for (int k = 0; k < 40 && beats_seen < 9; k++) begin
         step(next_word(), 1'b0);
         word_idx++;
      end
      check("midop_beats", 64'(beats_seen), 64'd9);
      reset_begin();
      check("midop_partial", 64'(exp_q.size()), 64'd0);
      bits_q.delete();
      exp_q.delete();
      add_random_blocks(30, 1'b1);
      reset_end();
      run_stream(0, 0, 1);
      wait_drain("midop_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
